// File: rtl/safe_mem_pkg.sv
// Shared defaults, FSM encoding and packed-bus helpers for the safe-side
// RAM write arbiter.
package safe_mem_pkg;

    localparam int DEF_NREQ      = 3;
    localparam int DEF_AW        = 4;
    localparam int DEF_DW        = 16;
    localparam int DEF_MAX_BURST = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // LSB position of field idx in a bus of equal-width packed fields
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/safe_mem_write_arbiter_rr_pick.sv
// Combinational round-robin picker: the first active request at or after
// rr_ptr wins, searching upward with wrap-around.
module rr_pick
    import safe_mem_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    // Scan NREQ positions starting at rr_ptr; the first hit is kept
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        winner  = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && req[(int'(rr_ptr) + k) % NREQ]) begin
                any_req = 1'b1;
                winner  = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/safe_mem_write_arbiter.sv
// Round-robin burst arbiter for the single write port of the safe/LCD
// dual-port RAM. Grants whole bursts, acks words combinationally and
// drives registered RAM write signals.
module safe_mem_write_arbiter
    import safe_mem_pkg::*;
#(
    parameter  int NREQ      = DEF_NREQ,
    parameter  int AW        = DEF_AW,
    parameter  int DW        = DEF_DW,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IW        = $clog2(NREQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      ack,
    output logic                 mem_wr_en,
    output logic [AW-1:0]        mem_wr_addr,
    output logic [DW-1:0]        mem_wr_data,
    output logic                 busy,
    output logic [IW-1:0]        owner
);

    // beat_cnt + 1 == MAX_BURST, written as a compare against a constant
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    arb_state_e      state;
    arb_state_e      state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   next_ptr;
    logic            any_req;
    logic [CW-1:0]   beat_cnt;
    logic            owner_req;
    logic            owner_last;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            limit_hit;
    logic            accept;
    logic            burst_end;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Select the current owner's request, last flag and offered word
    always_comb begin
        owner_req  = req[owner];
        owner_last = req_last[owner];
        sel_addr   = req_addr[field_lsb(int'(owner), AW) +: AW];
        sel_data   = req_data[field_lsb(int'(owner), DW) +: DW];
        limit_hit  = (beat_cnt == LAST_BEAT);
        next_ptr   = (owner == LAST_IDX) ? '0 : owner + IW'(1);
    end

    // Next-state, ack decode and burst termination
    always_comb begin
        state_next = state;
        ack        = '0;
        accept     = 1'b0;
        burst_end  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (owner_req) begin
                    ack[owner] = 1'b1;
                    accept     = 1'b1;
                    burst_end  = owner_last || limit_hit;
                end else begin
                    // Owner withdrew mid-burst: abort without a write
                    burst_end = 1'b1;
                end
                if (burst_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping: owner latch, beat counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                owner    <= winner;
                beat_cnt <= '0;
            end
        end else begin
            if (accept) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (burst_end) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Registered RAM write port: one write per accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= accept;
            if (accept) begin
                mem_wr_addr <= sel_addr;
                mem_wr_data <= sel_data;
            end
        end
    end

    assign busy = (state == BURST);

    // At most one requester is ever acked in a cycle
    ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));

    // The beat counter saturates at MAX_BURST by construction
    beat_bound: assert property (@(posedge clk) disable iff (rst)
                                 beat_cnt <= CW'(MAX_BURST));

endmodule

// File: tb/tb_safe_mem_write_arbiter.sv
// Scoreboard bench for safe_mem_write_arbiter: requester queues drive the
// handshake, expected RAM writes are queued up front and popped as writes
// appear.
module tb_safe_mem_write_arbiter;
    import safe_mem_pkg::*;

    localparam int NREQ      = 3;
    localparam int AW        = 4;
    localparam int DW        = 16;
    localparam int MAX_BURST = 8;
    localparam int IW        = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     ack;
    logic                mem_wr_en;
    logic [AW-1:0]       mem_wr_addr;
    logic [DW-1:0]       mem_wr_data;
    logic                busy;
    logic [IW-1:0]       owner;

    safe_mem_write_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    word_t           rq [NREQ][$];
    wr_t             sb [$];
    int              wr_cyc [$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc   = 0;
    logic [NREQ-1:0] ack_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Present each requester's head word, or drop req when its queue is empty
    task automatic present();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                req[i]                = 1'b1;
                req_addr[i*AW +: AW]  = rq[i][0].addr;
                req_data[i*DW +: DW]  = rq[i][0].data;
                req_last[i]           = rq[i][0].last;
            end else begin
                req[i]      = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic start();
        present();
        #1;
        ack_s = ack;
    endtask

    // One clock: retire acked words, re-present, then sample at the negedge
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        present();
        @(negedge clk);
        cyc++;
        ack_s = ack;
        if (mem_wr_en) begin
            wr_t e;
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("sb_unexpected_write", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("sb_addr", mem_wr_addr, e.addr);
                check("sb_data", mem_wr_data, e.data);
            end
        end
    endtask

    task automatic drain(input string tag, input int limit);
        int   n = 0;
        logic pending = 1'b1;
        while (pending && n < limit) begin
            step();
            n++;
            pending = busy || mem_wr_en;
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i].size() != 0) pending = 1'b1;
            end
        end
        check({"drain_", tag}, pending, 0);
    endtask

    task automatic push_word(input int r, input int a, input logic [DW-1:0] d,
                             input logic l, input logic expect_write);
        word_t w;
        wr_t   e;
        w.addr = AW'(a);
        w.data = d;
        w.last = l;
        rq[r].push_back(w);
        if (expect_write) begin
            e.addr = AW'(a);
            e.data = d;
            sb.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_gap [12] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 1, 1, 1};

        rst      = 1'b1;
        req      = '0;
        req_last = '0;
        req_addr = '0;
        req_data = '0;
        ack_s    = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_ack",   ack,       0);
        check("rst_busy",  busy,      0);
        check("rst_owner", owner,     0);
        check("rst_addr",  mem_wr_addr, 0);
        check("rst_data",  mem_wr_data, 0);
        rst = 1'b0;
        repeat (2) step();

        // Single burst from requester 1: addresses 2,3,4
        push_word(1, 2, 16'h0101, 1'b0, 1'b1);
        push_word(1, 3, 16'h0202, 1'b0, 1'b1);
        push_word(1, 4, 16'h0303, 1'b1, 1'b1);
        start();
        check("single_n_ack",   ack,  0);
        check("single_n_busy",  busy, 0);
        step();
        check("single_n1_ack",   ack,       3'b010);
        check("single_n1_wr_en", mem_wr_en, 0);
        check("single_n1_busy",  busy,      1);
        check("single_n1_owner", owner,     1);
        step();
        check("single_n2_ack",   ack,         3'b010);
        check("single_n2_wr_en", mem_wr_en,   1);
        check("single_n2_addr",  mem_wr_addr, 2);
        step();
        check("single_n3_ack",   ack,         3'b010);
        check("single_n3_addr",  mem_wr_addr, 3);
        step();
        check("single_n4_ack",   ack,         0);
        check("single_n4_busy",  busy,        0);
        check("single_n4_wr_en", mem_wr_en,   1);
        check("single_n4_addr",  mem_wr_addr, 4);
        step();
        check("single_n5_wr_en", mem_wr_en, 0);
        drain("single", 20);

        // Abort by requester 2 after two words; requester 0 waits its turn.
        // rr_ptr is 2 after the single burst, so 2 must win over 0.
        push_word(2, 10, 16'hAA01, 1'b0, 1'b1);
        push_word(2, 11, 16'hAA02, 1'b0, 1'b1);
        push_word(0, 5,  16'h5555, 1'b1, 1'b1);
        start();
        step();
        check("abort_owner",    owner, 2);
        check("abort_ack1",     ack,   3'b100);
        step();
        check("abort_ack2",     ack,   3'b100);
        step();
        check("abort_drop_ack",  ack,         0);
        check("abort_drop_busy", busy,        1);
        check("abort_drop_addr", mem_wr_addr, 11);
        step();
        check("abort_idle_busy",  busy,      0);
        check("abort_idle_wr_en", mem_wr_en, 0);
        drain("abort", 20);

        // Reset asserted in the cycle after an ack; the acked word is dropped
        push_word(1, 7, 16'h7777, 1'b0, 1'b0);
        push_word(1, 8, 16'h8888, 1'b0, 1'b0);
        push_word(1, 9, 16'h9999, 1'b1, 1'b0);
        start();
        step();
        check("rstmid_ack",   ack,   3'b010);
        check("rstmid_owner", owner, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        present();
        ack_s = '0;
        #1;
        check("rstmid_wr_en", mem_wr_en, 0);
        check("rstmid_busy",  busy,      0);
        check("rstmid_ack0",  ack,       0);
        check("rstmid_own0",  owner,     0);
        repeat (2) step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check("idle_wr_en", mem_wr_en, 0);
            check("idle_ack",   ack,       0);
            check("idle_busy",  busy,      0);
            check("idle_owner", owner,     0);
        end

        // Round-robin with all three requesting single-word bursts
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                push_word(i, i + 4 * k, 16'hC000 | DW'(k << 8) | DW'(i), 1'b1, 1'b1);
            end
        end
        wr_cyc.delete();
        start();
        drain("rr", 60);
        check("rr_writes", wr_cyc.size(), 6);
        for (int j = 1; j < wr_cyc.size(); j++) begin
            check("rr_gap", wr_cyc[j] - wr_cyc[j-1], 2);
        end

        // MAX_BURST cut: requester 0 streams 12 words, requester 2 slips in
        for (int j = 0; j < 8; j++) push_word(0, j, 16'hA000 + DW'(j), 1'b0, 1'b1);
        push_word(2, 15, 16'hBEEF, 1'b1, 1'b1);
        for (int j = 8; j < 12; j++) push_word(0, j, 16'hA000 + DW'(j), 1'b0, 1'b1);
        wr_cyc.delete();
        start();
        drain("maxb", 100);
        check("maxb_writes", wr_cyc.size(), 13);
        for (int j = 1; j < wr_cyc.size() && j <= 12; j++) begin
            check("maxb_gap", wr_cyc[j] - wr_cyc[j-1], exp_gap[j-1]);
        end

        check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/safe_mem_write_arbiter.md
# safe_mem_write_arbiter

Shares the single write port of the safe/LCD dual-port RAM between several safe-side requesters: the status writer, the message-text writer and the guess-counter logger. Each requester presents an address/data stream with a request/acknowledge handshake. The arbiter grants whole bursts in round-robin order and drives registered RAM write signals. It sits in the safe_clk domain, directly in front of the RAM write port.

## Interface
- NREQ, 3: number of requesters (2..8)
- AW, 4: RAM address width
- DW, 16: RAM data width
- MAX_BURST, 8: maximum words per grant before forced hand-over (1..2^AW)
- clk  in  1  safe-side clock (divided safe_clk); the block's one clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request; held high while a word is offered
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
- req_last  in  NREQ  offered word is the final word of the burst
- ack  out  NREQ  word accepted this cycle (one-hot or zero)
- mem_wr_en  out  1  RAM write enable (registered)
- mem_wr_addr  out  AW  RAM write address (registered)
- mem_wr_data  out  DW  RAM write data (registered)
- busy  out  1  high while in BURST
- owner  out  $clog2(NREQ)  index of the current or last grantee

## Operation
- The FSM has two states, IDLE and BURST.
- IDLE behaviour:
  - If any req is high, the winner is the first requester at or after rr_ptr, searching upward with wrap-around.
  - On the clock edge, owner is set to the winner, the state moves to BURST and beat_cnt is cleared.
  - No ack is issued and no write is made while in IDLE.
- BURST behaviour:
  - ack[owner] = req[owner] (combinational). All other ack bits are 0.
  - On an edge with ack high, the offered word is registered into mem_wr_*, mem_wr_en is set to 1 and beat_cnt increments.
  - On an edge with no ack, mem_wr_en is set to 0.
- A burst ends, returning the FSM to IDLE and setting rr_ptr to owner+1 mod NREQ, when any of these occurs:
  - The accepted word has req_last = 1.
  - beat_cnt reaches MAX_BURST after the current accept.
  - req[owner] is low in a BURST cycle. This is an abort: no ack, no write.
- beat_cnt is $clog2(MAX_BURST+1) bits wide and never wraps. The limit check uses beat_cnt+1 == MAX_BURST.
- Requests from non-owners are ignored during BURST. They are arbitrated at the next IDLE.
- A requester may change addr/data/last only after an edge on which its ack was high.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, owner 0, beat_cnt 0.
  - mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0.
  - busy 0, ack 0.
- Grant latency: req rises in cycle n (IDLE), so the first ack occurs in cycle n+1.
- Write latency: a word acked in cycle k appears on mem_wr_* with mem_wr_en=1 in cycle k+1, for exactly one cycle per word.
- Throughput: 1 word/cycle within a burst. There is always exactly one idle (no-write) cycle between consecutive bursts, including back-to-back bursts by the same requester.
- Simultaneous requests are resolved purely by rr_ptr. There is no fixed priority.
- Reset asserted mid-burst: all state and outputs are cleared immediately and asynchronously. The in-flight registered word is dropped, with no write.

## Structure
- Package safe_mem_pkg holds:
  - AW and DW defaults.
  - The state encoding (IDLE=0, BURST=1).
  - The MAX_BURST default.
  - The packed-field index helpers.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], rr_ptr.
  - Outputs: winner index and any_req.
- All remaining logic lives in the top module: FSM, beat counter, output registers and ack decode.

## Test plan
- Reset/idle:
  - Stimulus: rst=1 mid-run, then rst=0, with all req low.
  - Required response: mem_wr_en=0, ack=0, busy=0, owner=0, and no writes for 20 cycles.
- Single burst:
  - Stimulus: requester 1 offers addr 2,3,4 with data 16'h0101, 16'h0202, 16'h0303; req_last is set on the third word.
  - Required response: ack[1] in cycles n+1..n+3; writes to addresses 2,3,4 in cycles n+2..n+4; busy drops after the third word; rr_ptr=2.
- Round-robin:
  - Stimulus: req=3'b111 held, with single-word bursts (req_last=1).
  - Required response: the grant order is 0,1,2,0,1,2, with one idle cycle between consecutive writes.
- MAX_BURST cut:
  - Stimulus: requester 0 streams 12 words with req_last=0 while requester 2 also requests.
  - Required response: 8 writes, then IDLE, then requester 2 is granted; requester 0 resumes later at its 9th word.
- Abort:
  - Stimulus: requester 2 drops req after 2 acked words.
  - Required response: exactly 2 writes, no ack in the drop cycle, and a return to IDLE.
- Reset mid-burst:
  - Stimulus: rst is asserted in the cycle after an ack.
  - Required response: mem_wr_en is 0 immediately; that word is never written; state returns to IDLE.
